fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit core; sits directly upstream of decode and drives the instruction cache read port (icache_r_en / icache_addr / icache_data).
- Holds the fetch PC and issues one word read at a time.
- Buffers returned instructions in a small FIFO and hands them to decode under a valid/stall handshake.
- Handles control-flow redirects from execute, discarding in-flight or stale words.

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_buffer.sv | 85 ++++++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Constants and types shared by the front-end blocks of the 16-bit core.
package core_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction cache read port: fetch side drives the request, cache side answers.
interface fetch_unit_if #(
  parameter int ADDR_W = core_pkg::ADDR_W,
  parameter int DATA_W = core_pkg::DATA_W
);

  logic              icache_r_en;
  logic [ADDR_W-1:0] icache_addr;
  logic [DATA_W-1:0] icache_data;
  logic              icache_valid;

  modport master (
    output icache_r_en,
    output icache_addr,
    input  icache_data,
    input  icache_valid
  );

  modport slave (
    input  icache_r_en,
    input  icache_addr,
    output icache_data,
    output icache_valid
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} between the cache port and decode; head is read combinationally.
module fetch_buffer #(
  parameter  int DEPTH  = 2,
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  logic [DEPTH-1:0][ADDR_W-1:0] pc_flat;
  logic [DEPTH-1:0][DATA_W-1:0] instr_flat;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [ADDR_W-1:0] pc_reg;
    logic [DATA_W-1:0] instr_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pc_reg    <= '0;
        instr_reg <= '0;
      end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
        pc_reg    <= push_pc;
        instr_reg <= push_instr;
      end
    end

    assign pc_flat[gi]    = pc_reg;
    assign instr_flat[gi] = instr_reg;
  end

  assign head_pc    = pc_flat[rd_ptr_reg];
  assign head_instr = instr_flat[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, one outstanding icache read at a time, and the
// redirect/discard state machine feeding the instruction buffer.
module fetch_unit
  import core_pkg::*;
#(
  parameter int                      ADDR_W    = core_pkg::ADDR_W,
  parameter int                      DATA_W    = core_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]       RESET_PC  = core_pkg::RESET_PC,
  parameter int                      BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      icache,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(BUF_DEPTH - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_DROP = DROP;

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
  logic [ADDR_W-1:0] seq_pc;
  logic              push, pop;
  logic              room_after_push;
  logic              buf_full, buf_empty;
  logic [CNT_W-1:0]  buf_count;

  assign instr_valid = !buf_empty;
  assign pop  = instr_valid && !stall && !redirect_en;
  assign push = (state_reg == S_REQ) && icache.icache_valid && !redirect_en;

  assign icache.icache_r_en = (state_reg == S_REQ) || (state_reg == S_DROP);
  assign icache.icache_addr = req_addr_reg;

  assign seq_pc = req_addr_reg + ADDR_W'(1);
  // After this push the buffer still has a slot for the next word only if the head
  // leaves now or at least two slots were free beforehand.
  assign room_after_push = pop || (buf_count < LAST_FREE);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_addr_next = req_addr_reg;
    case (state_reg)
      S_IDLE: begin
        if (redirect_en) begin
          state_next    = S_REQ;
          fetch_pc_next = redirect_pc;
          req_addr_next = redirect_pc;
        end else if (!buf_full) begin
          state_next    = S_REQ;
          req_addr_next = fetch_pc_reg;
        end
      end
      S_REQ: begin
        if (redirect_en) begin
          fetch_pc_next = redirect_pc;
          if (icache.icache_valid) begin
            req_addr_next = redirect_pc;
          end else begin
            state_next = S_DROP;
          end
        end else if (icache.icache_valid) begin
          fetch_pc_next = seq_pc;
          if (room_after_push) begin
            req_addr_next = seq_pc;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DROP: begin
        // The stale request must still run to completion before anything new issues.
        if (redirect_en) begin
          fetch_pc_next = redirect_pc;
          if (icache.icache_valid) begin
            state_next    = S_REQ;
            req_addr_next = redirect_pc;
          end
        end else if (icache.icache_valid) begin
          state_next    = S_REQ;
          req_addr_next = fetch_pc_reg;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_addr_reg <= req_addr_next;
    end
  end

  fetch_buffer #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_en),
    .push       (push),
    .push_pc    (req_addr_reg),
    .push_instr (icache.icache_data),
    .pop        (pop),
    .head_pc    (instr_pc),
    .head_instr (instr),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with a behavioural icache and an
// in-order instruction-stream model of what decode must receive.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .icache      (bus),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // icache model controls, written only by the main sequence
  int fixed_lat   = 0;
  bit rand_mode   = 0;
  bit stale_pulse = 0;

  // icache model state, written only by the cache process
  int          proto_err = 0;
  logic [15:0] req_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cache: answers lat cycles after a request appears; addr must stay put until answered.
  initial begin : cache_model
    int          wait_cnt;
    int          lat_now;
    bit          in_req;
    logic [15:0] seen_addr;
    wait_cnt = 0;
    lat_now  = 0;
    in_req   = 0;
    seen_addr = '0;
    bus.icache_valid = 1'b0;
    bus.icache_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_req = 0;
        wait_cnt = 0;
        bus.icache_valid = 1'b0;
      end else if (bus.icache_r_en) begin
        if (!in_req) begin
          in_req    = 1;
          wait_cnt  = 0;
          lat_now   = rand_mode ? int'($urandom_range(0, 3)) : fixed_lat;
          seen_addr = bus.icache_addr;
          req_log.push_back(bus.icache_addr);
        end else if (bus.icache_addr !== seen_addr) begin
          proto_err++;
        end
        if (wait_cnt >= lat_now) begin
          bus.icache_valid = 1'b1;
          bus.icache_data  = mem_word(bus.icache_addr);
          in_req = 0;
        end else begin
          bus.icache_valid = 1'b0;
          wait_cnt++;
        end
      end else begin
        in_req = 0;
        bus.icache_valid = stale_pulse;
        bus.icache_data  = 16'hDEAD;
      end
    end
  end

  // Leaves the bench 1 time unit after the edge that starts cycle 0 (reset released).
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int   base;
    bit   got;
    int   consumed;
    logic [15:0] exp_pc;

    reset = 1'b0;
    stall = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;

    // Reset state
    #3;
    chk("rst_r_en", 32'(bus.icache_r_en), 32'd0);
    chk("rst_addr", 32'(bus.icache_addr), 32'h0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);

    // Zero-wait streaming
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("t1_r_en_idle", 32'(bus.icache_r_en), 32'd0);
      end else begin
        chk("t1_r_en", 32'(bus.icache_r_en), 32'd1);
        chk("t1_addr", 32'(bus.icache_addr), 32'(c - 1));
      end
      if (c >= 2) begin
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_pc", 32'(instr_pc), 32'(c - 2));
        chk("t1_instr", 32'(instr), 32'(mem_word(16'(c - 2))));
      end
      next_cycle();
    end

    // Redirect into DROP, then redirect across the address wrap
    fixed_lat = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      case (c)
        6:  fixed_lat = 2;
        7:  begin redirect_en = 1'b1; redirect_pc = 16'h0100; end
        8:  begin redirect_en = 1'b0; fixed_lat = 0; end
        11: begin redirect_en = 1'b1; redirect_pc = 16'hFFFE; end
        12: redirect_en = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      case (c)
        6, 7: begin
          chk("t3_r_en_pending", 32'(bus.icache_r_en), 32'd1);
          chk("t3_addr_pending", 32'(bus.icache_addr), 32'h0005);
        end
        8: begin
          chk("t3_drop_r_en", 32'(bus.icache_r_en), 32'd1);
          chk("t3_drop_addr", 32'(bus.icache_addr), 32'h0005);
          chk("t3_drop_valid", 32'(instr_valid), 32'd0);
        end
        9: begin
          chk("t3_new_addr", 32'(bus.icache_addr), 32'h0100);
          chk("t3_new_valid", 32'(instr_valid), 32'd0);
        end
        10: begin
          chk("t3_first_valid", 32'(instr_valid), 32'd1);
          chk("t3_first_pc", 32'(instr_pc), 32'h0100);
          chk("t3_first_instr", 32'(instr), 32'(mem_word(16'h0100)));
        end
        12: begin
          chk("t4_addr", 32'(bus.icache_addr), 32'hFFFE);
          chk("t4_flushed", 32'(instr_valid), 32'd0);
        end
        13: begin
          chk("t4_pc_fffe", 32'(instr_pc), 32'hFFFE);
          chk("t4_instr_fffe", 32'(instr), 32'(mem_word(16'hFFFE)));
          chk("t4_addr_ffff", 32'(bus.icache_addr), 32'hFFFF);
        end
        14: begin
          chk("t4_pc_ffff", 32'(instr_pc), 32'hFFFF);
          chk("t4_instr_ffff", 32'(instr), 32'(mem_word(16'hFFFF)));
          chk("t4_addr_wrap", 32'(bus.icache_addr), 32'h0000);
        end
        15: begin
          chk("t4_pc_wrap", 32'(instr_pc), 32'h0000);
          chk("t4_instr_wrap", 32'(instr), 32'(mem_word(16'h0000)));
        end
        default: ;
      endcase
      next_cycle();
    end

    // Stall with latency-3 cache: buffer fills after exactly two requests
    fixed_lat = 2;
    stall = 1'b1;
    base = req_log.size();
    do_reset();
    repeat (11) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t2_req_count", 32'(req_log.size() - base), 32'd2);
    if (req_log.size() >= base + 2) begin
      chk("t2_req0", 32'(req_log[base]), 32'h0000);
      chk("t2_req1", 32'(req_log[base + 1]), 32'h0001);
    end
    chk("t2_r_en_idle", 32'(bus.icache_r_en), 32'd0);
    chk("t2_hold_valid", 32'(instr_valid), 32'd1);
    chk("t2_hold_pc", 32'(instr_pc), 32'h0000);
    chk("t2_hold_instr", 32'(instr), 32'(mem_word(16'h0000)));
    next_cycle();
    stall = 1'b0;
    @(negedge clk);
    chk("t2_rel_pc0", 32'(instr_pc), 32'h0000);
    chk("t2_rel_instr0", 32'(instr), 32'(mem_word(16'h0000)));
    next_cycle();
    @(negedge clk);
    chk("t2_rel_pc1", 32'(instr_pc), 32'h0001);
    chk("t2_rel_instr1", 32'(instr), 32'(mem_word(16'h0001)));
    next_cycle();
    @(negedge clk);
    chk("t2_resume_r_en", 32'(bus.icache_r_en), 32'd1);
    chk("t2_resume_addr", 32'(bus.icache_addr), 32'h0002);
    chk("t2_resume_empty", 32'(instr_valid), 32'd0);
    next_cycle();

    // Refill to two entries, then redirect + returned word + pop in one cycle
    stall = 1'b1;
    fixed_lat = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (!bus.icache_r_en) got = 1;
      else next_cycle();
    end
    chk("t5_refill_done", 32'(got), 32'd1);
    chk("t5_head_pc", 32'(instr_pc), 32'h0002);
    chk("t5_head_instr", 32'(instr), 32'(mem_word(16'h0002)));
    next_cycle();
    stall = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 16'h0040;
    stale_pulse = 1'b1;
    next_cycle();
    redirect_en = 1'b0;
    stale_pulse = 1'b0;
    @(negedge clk);
    chk("t5_flushed", 32'(instr_valid), 32'd0);
    chk("t5_r_en", 32'(bus.icache_r_en), 32'd1);
    chk("t5_target", 32'(bus.icache_addr), 32'h0040);
    next_cycle();
    stall = 1'b1;
    fixed_lat = 3;
    @(negedge clk);
    chk("t5_first_pc", 32'(instr_pc), 32'h0040);
    chk("t5_first_instr", 32'(instr), 32'(mem_word(16'h0040)));
    next_cycle();

    // Asynchronous reset in the middle of an outstanding request
    chk("t6_pre_r_en", 32'(bus.icache_r_en), 32'd1);
    chk("t6_pre_valid", 32'(instr_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_r_en", 32'(bus.icache_r_en), 32'd0);
    chk("t6_addr", 32'(bus.icache_addr), 32'h0000);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_instr", 32'(instr), 32'd0);
    chk("t6_pc", 32'(instr_pc), 32'd0);
    next_cycle();
    reset = 1'b1;
    stall = 1'b0;
    fixed_lat = 0;
    stale_pulse = 1'b1;
    @(negedge clk);
    chk("t6_idle_r_en", 32'(bus.icache_r_en), 32'd0);
    chk("t6_idle_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    stale_pulse = 1'b0;
    @(negedge clk);
    chk("t6_stale_ignored", 32'(instr_valid), 32'd0);
    chk("t6_refetch_addr", 32'(bus.icache_addr), 32'h0000);
    chk("t6_refetch_r_en", 32'(bus.icache_r_en), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("t6_first_pc", 32'(instr_pc), 32'h0000);
    chk("t6_first_instr", 32'(instr), 32'(mem_word(16'h0000)));
    next_cycle();

    // Random stall/redirect/latency against the in-order stream model
    rand_mode = 1;
    stall = 1'b0;
    do_reset();
    exp_pc = 16'h0000;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 99) < 30);
      redirect_en = ($urandom_range(0, 99) < 4);
      redirect_pc = 16'($urandom);
      @(negedge clk);
      if (instr_valid) begin
        chk("rnd_pc", 32'(instr_pc), 32'(exp_pc));
        chk("rnd_instr", 32'(instr), 32'(mem_word(exp_pc)));
      end
      if (redirect_en) begin
        exp_pc = redirect_pc;
      end else if (instr_valid && !stall) begin
        exp_pc = exp_pc + 16'd1;
        consumed++;
      end
      next_cycle();
      if (c > 0 && redirect_en) begin
        @(negedge clk);
        chk("rnd_flush", 32'(instr_valid), 32'd0);
        next_cycle();
      end
    end
    stall = 1'b0;
    redirect_en = 1'b0;
    chk("rnd_progress", 32'(consumed >= 200), 32'd1);
    chk("cache_protocol", 32'(proto_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
